// File: rtl/sync_fifo_ctl_if.sv
// Bundles the data, handshake and status signals of the single-clock FIFO.
// Latency: none; these are plain wires between producer/consumer and the FIFO.
// Backpressure: the producer must watch full, the consumer must watch empty.
interface sync_fifo_ctl_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr;
    logic [WIDTH-1:0]      din;
    logic                  rd;
    logic [WIDTH-1:0]      dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    // Side that pushes, pops and clears errors.
    modport master (
        output wr, din, rd, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    // The FIFO itself.
    modport slave (
        input  wr, din, rd, clr_err,
        output dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock power-of-two FIFO with fill count, almost thresholds and sticky errors.
// Latency: show-ahead mode shows the word 1 cycle after its write; registered mode 1 cycle after rd.
// Backpressure: writes while full and reads while empty are dropped and flagged.
module sync_fifo_ctl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter bit FWFT       = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_ctl_if.slave fifo
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_C    = (DEPTH_LOG2+1)'(AF_LEVEL);
    localparam logic [DEPTH_LOG2:0] AE_C    = (DEPTH_LOG2+1)'(AE_LEVEL);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr;
    logic [DEPTH_LOG2:0]   rptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [WIDTH-1:0]      head_dat;

    // Acceptance uses the registered flags, so a full FIFO with wr&&rd takes only the read.
    always_comb begin
        wr_acc     = fifo.wr && !full_q;
        rd_acc     = fifo.rd && !empty_q;
        count_next = count_q + {{DEPTH_LOG2{1'b0}}, wr_acc} - {{DEPTH_LOG2{1'b0}}, rd_acc};
        head_dat   = mem[rptr[DEPTH_LOG2-1:0]];
    end

    // Pointers, fill count and flags; flags are precomputed from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            count_q <= count_next;
            full_q  <= (count_next == DEPTH_C);
            empty_q <= (count_next == '0);
            af_q    <= (count_next >= AF_C);
            ae_q    <= (count_next <= AE_C);
        end
    end

    // Storage is left untouched by reset; only accepted writes land here.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wptr[DEPTH_LOG2-1:0]] <= fifo.din;
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (fifo.wr && full_q)   ovf_q <= 1'b1;
            else if (fifo.clr_err)   ovf_q <= 1'b0;
            if (fifo.rd && empty_q)  udf_q <= 1'b1;
            else if (fifo.clr_err)   udf_q <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_show_ahead
            // Head word is presented directly; blanked to zero while empty.
            always_comb begin
                fifo.dout = empty_q ? '0 : head_dat;
            end
        end else begin : g_registered
            logic [WIDTH-1:0] dout_q;
            // Output register loads the head only on an accepted read, otherwise holds.
            always_ff @(posedge clk) begin
                if (rst)         dout_q <= '0;
                else if (rd_acc) dout_q <= head_dat;
            end
            always_comb begin
                fifo.dout = dout_q;
            end
        end
    endgenerate

    // Status outputs straight from their registers.
    always_comb begin
        fifo.full         = full_q;
        fifo.empty        = empty_q;
        fifo.almost_full  = af_q;
        fifo.almost_empty = ae_q;
        fifo.count        = count_q;
        fifo.overflow     = ovf_q;
        fifo.underflow    = udf_q;
    end
endmodule
